hls_macc_0_key_loader: RTL

- Upstream companion of the locked HLS macc core.
- Shifts the obfuscation key in serially, one bit per handshake, and commits it atomically onto the `working` bus that feeds the core.
- Gates the core's `ap_start` so a run cannot begin before a full key is committed.
- Sequences one run per host request and reports completion.

---
 rtl/hls_macc_0_key_loader.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/hls_macc_0_key_loader.sv
// Serial key loader and run sequencer for the locked HLS macc core.
// The key is shifted in LSB first, one bit per vld/rdy handshake, and is
// committed to `working` in a single step. ap_start is held off until a full
// key is committed. One macc run is issued per host_start request.
// Optional build macro: HLS_MACC_KEY_PARITY_EN appends an even-parity bit to
// each load. A parity mismatch traps the loader in ERR until key_clr.
module hls_macc_0_key_loader #(
  parameter int unsigned KEY_WIDTH = 32,
  parameter int unsigned CNT_WIDTH = 6
) (
  input  logic                 ap_clk,
  input  logic                 ap_rst_n,
  input  logic                 key_in,
  input  logic                 key_in_vld,
  output logic                 key_in_rdy,
  input  logic                 key_clr,
  input  logic                 host_start,
  output logic                 ap_start,
  input  logic                 ap_ready_macc,
  input  logic                 ap_done_macc,
  output logic [KEY_WIDTH-1:0] working,
  output logic                 key_loaded,
  output logic                 busy,
  output logic                 run_done,
  output logic                 key_err
);

  typedef enum logic [2:0] {
    S_EMPTY = 3'd0,
    S_SHIFT = 3'd1,
    S_ARMED = 3'd2,
    S_RUN   = 3'd3,
    S_ERR   = 3'd4
  } state_t;

`ifdef HLS_MACC_KEY_PARITY_EN
  localparam logic [CNT_WIDTH-1:0] PAR_IDX = CNT_WIDTH'(KEY_WIDTH);
`else
  localparam logic [CNT_WIDTH-1:0] LAST_IDX = CNT_WIDTH'(KEY_WIDTH - 1);
`endif

  state_t               state_q, state_d;
  logic [KEY_WIDTH-1:0] shadow_q, shadow_d;
  logic [KEY_WIDTH-1:0] working_q, working_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 loaded_q, loaded_d;
  logic                 start_q, start_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 rdy_q, rdy_d;
  logic                 clr_pend_q, clr_pend_d;
  logic                 err_q, err_d;
  logic                 xfer;
  logic                 wipe_key;

  // State register and all registered outputs.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q    <= S_EMPTY;
      shadow_q   <= '0;
      working_q  <= '0;
      cnt_q      <= '0;
      loaded_q   <= 1'b0;
      start_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rdy_q      <= 1'b0;
      clr_pend_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      shadow_q   <= shadow_d;
      working_q  <= working_d;
      cnt_q      <= cnt_d;
      loaded_q   <= loaded_d;
      start_q    <= start_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      rdy_q      <= rdy_d;
      clr_pend_q <= clr_pend_d;
      err_q      <= err_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d    = state_q;
    shadow_d   = shadow_q;
    working_d  = working_q;
    cnt_d      = cnt_q;
    loaded_d   = loaded_q;
    start_d    = start_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    clr_pend_d = clr_pend_q;
    err_d      = err_q;
    wipe_key   = 1'b0;
    xfer       = key_in_vld & rdy_q;

    case (state_q)
      S_EMPTY, S_SHIFT: begin
        if (key_clr) begin
          wipe_key = 1'b1;
        end else if (xfer) begin
          for (int unsigned i = 0; i < KEY_WIDTH; i++) begin
            if (cnt_q == CNT_WIDTH'(i)) shadow_d[i] = key_in;
          end
          cnt_d   = cnt_q + CNT_WIDTH'(1);
          state_d = S_SHIFT;
`ifdef HLS_MACC_KEY_PARITY_EN
          if (cnt_q == PAR_IDX) begin
            cnt_d = '0;
            if (key_in == ^shadow_q) begin
              working_d = shadow_q;
              loaded_d  = 1'b1;
              state_d   = S_ARMED;
            end else begin
              err_d   = 1'b1;
              state_d = S_ERR;
            end
          end
`else
          if (cnt_q == LAST_IDX) begin
            working_d = shadow_d;
            loaded_d  = 1'b1;
            cnt_d     = '0;
            state_d   = S_ARMED;
          end
`endif
        end
      end
      S_ARMED: begin
        if (key_clr) begin
          wipe_key = 1'b1;
        end else if (host_start) begin
          start_d = 1'b1;
          busy_d  = 1'b1;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (key_clr) clr_pend_d = 1'b1;
        if (ap_ready_macc) start_d = 1'b0;
        if (ap_done_macc) begin
          start_d    = 1'b0;
          busy_d     = 1'b0;
          done_d     = 1'b1;
          clr_pend_d = 1'b0;
          state_d    = S_ARMED;
          if (clr_pend_q || key_clr) wipe_key = 1'b1;
        end
      end
`ifdef HLS_MACC_KEY_PARITY_EN
      S_ERR: begin
        if (key_clr) begin
          wipe_key = 1'b1;
          err_d    = 1'b0;
        end
      end
`endif
      default: begin
        wipe_key = 1'b1;
        start_d  = 1'b0;
        busy_d   = 1'b0;
        err_d    = 1'b0;
      end
    endcase

    // Discard the key and restart collection.
    if (wipe_key) begin
      shadow_d  = '0;
      cnt_d     = '0;
      working_d = '0;
      loaded_d  = 1'b0;
      state_d   = S_EMPTY;
    end

    rdy_d = (state_d == S_EMPTY) || (state_d == S_SHIFT);
  end

  assign key_in_rdy = rdy_q;
  assign ap_start   = start_q;
  assign working    = working_q;
  assign key_loaded = loaded_q;
  assign busy       = busy_q;
  assign run_done   = done_q;
`ifdef HLS_MACC_KEY_PARITY_EN
  assign key_err    = err_q;
`else
  assign key_err    = 1'b0;
`endif

endmodule
